bankswitch_detect: RTL and testbench

Cartridge-load controller that decides the bank-switching scheme of a ROM image while it streams into cartridge RAM. It sequences the load (start, byte beats, done) and drives four signature matchers from the same byte stream. It counts image size and checks for a Superchip RAM window. At end of load it resolves a scheme code for the cartridge mapper.

---
 rtl/bankswitch_pkg.sv | 48 ++++
 rtl/sig_matcher.sv | 49 ++++
 rtl/bankswitch_detect.sv | 100 ++++++++++
 tb/tb_bankswitch_detect.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bankswitch_pkg.sv
// Shared constants for the cartridge bank-switch detector: scheme codes,
// signature patterns, image sizes and the scheme resolution rule.
package bankswitch_pkg;

  localparam logic [3:0] SCH_2K      = 4'd0;
  localparam logic [3:0] SCH_4K      = 4'd1;
  localparam logic [3:0] SCH_F8      = 4'd2;
  localparam logic [3:0] SCH_F6      = 4'd3;
  localparam logic [3:0] SCH_F4      = 4'd4;
  localparam logic [3:0] SCH_E0      = 4'd5;
  localparam logic [3:0] SCH_3F      = 4'd6;
  localparam logic [3:0] SCH_FE      = 4'd7;
  localparam logic [3:0] SCH_E7      = 4'd8;
  localparam logic [3:0] SCH_UNKNOWN = 4'd15;

  localparam int unsigned SIG_E0_LEN = 3;
  localparam int unsigned SIG_3F_LEN = 2;
  localparam int unsigned SIG_FE_LEN = 5;
  localparam int unsigned SIG_E7_LEN = 3;

  localparam logic [8*SIG_E0_LEN-1:0] SIG_E0 = 24'h8DE01F;
  localparam logic [8*SIG_3F_LEN-1:0] SIG_3F = 16'h853F;
  localparam logic [8*SIG_FE_LEN-1:0] SIG_FE = 40'h2000D0C6C5;
  localparam logic [8*SIG_E7_LEN-1:0] SIG_E7 = 24'hADE5FF;

  localparam logic [15:0] SIZE_2K   = 16'd2048;
  localparam logic [15:0] SIZE_4K   = 16'd4096;
  localparam logic [15:0] SIZE_8K   = 16'd8192;
  localparam logic [15:0] SIZE_16K  = 16'd16384;
  localparam logic [15:0] SIZE_32K  = 16'd32768;
  localparam logic [15:0] SIZE_MAX  = 16'hFFFF;
  localparam logic [15:0] SC_WINDOW = 16'd256;

  // Priority-ordered scheme choice from final image size and matcher hits.
  function automatic logic [3:0] resolve_scheme(input logic [15:0] size,
                                                input logic e0, input logic p3f,
                                                input logic fe, input logic e7);
    logic [3:0] sch;
    if (size == SIZE_2K)       sch = SCH_2K;
    else if (size == SIZE_4K)  sch = SCH_4K;
    else if (size == SIZE_8K)  sch = e0 ? SCH_E0 : p3f ? SCH_3F : fe ? SCH_FE : SCH_F8;
    else if (size == SIZE_16K) sch = e7 ? SCH_E7 : SCH_F6;
    else if (size == SIZE_32K) sch = SCH_F4;
    else                       sch = p3f ? SCH_3F : SCH_UNKNOWN;
    return sch;
  endfunction

endpackage

// File: rtl/sig_matcher.sv
// Counts occurrences of a fixed byte signature in a byte stream and flags
// once the count reaches NEED.
module sig_matcher #(
  parameter int unsigned NUM_BYTES = 3,
  parameter logic [8*NUM_BYTES-1:0] PATTERN = '0,
  parameter int unsigned NEED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       ena,
  input  logic [7:0] data,
  output logic       hit
);

  localparam int unsigned W      = 8 * NUM_BYTES;
  localparam int unsigned FILL_W = $clog2(NUM_BYTES + 1);

  logic [W-1:0]      window;
  logic [W-1:0]      shifted_c;
  logic [FILL_W-1:0] fill;
  logic [7:0]        count;
  logic [7:0]        count_next_c;
  logic              match_c;

  // Compare against the window including the current byte so a match on the
  // final beat is counted in the same cycle.
  always_comb begin
    shifted_c    = {window[W-9:0], data};
    match_c      = ena && (fill >= FILL_W'(NUM_BYTES - 1)) && (shifted_c == PATTERN);
    count_next_c = count;
    if (match_c && (count != 8'hFF)) count_next_c = count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      window <= '0;
      fill   <= '0;
      count  <= '0;
      hit    <= 1'b0;
    end else if (ena) begin
      window <= shifted_c;
      if (fill != FILL_W'(NUM_BYTES)) fill <= fill + FILL_W'(1);
      count  <= count_next_c;
      hit    <= (count_next_c >= 8'(NEED));
    end
  end

endmodule

// File: rtl/bankswitch_detect.sv
// Cartridge-load controller: sequences a ROM image load, tracks size and the
// Superchip RAM window, and resolves the bank-switching scheme at the end.
module bankswitch_detect
  import bankswitch_pkg::*;
#(
  parameter int unsigned E0_NEED  = 1,
  parameter int unsigned P3F_NEED = 2,
  parameter int unsigned FE_NEED  = 1,
  parameter int unsigned E7_NEED  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        ena,
  input  logic [7:0]  data,
  input  logic        load_done,
  output logic        busy,
  output logic [3:0]  scheme,
  output logic        superchip,
  output logic        scheme_valid,
  output logic [15:0] rom_size
);

  typedef enum logic [1:0] {IDLE, LOADING, RESOLVE, DONE} state_t;

  state_t     state;
  logic       accept_c;
  logic       hit_e0, hit_3f, hit_fe, hit_e7;
  logic [7:0] sc_ref;
  logic       sc_ok;
  logic [3:0] scheme_c;
  logic       superchip_c;

  // A byte is taken only while loading, and never in a restart cycle.
  always_comb begin
    accept_c    = (state == LOADING) && ena && !load_start;
    scheme_c    = resolve_scheme(rom_size, hit_e0, hit_3f, hit_fe, hit_e7);
    superchip_c = sc_ok && (rom_size >= SC_WINDOW) &&
                  ((scheme_c == SCH_F8) || (scheme_c == SCH_F6) || (scheme_c == SCH_F4));
  end

  sig_matcher #(.NUM_BYTES(SIG_E0_LEN), .PATTERN(SIG_E0), .NEED(E0_NEED)) u_match_e0 (
    .clk(clk), .reset(reset), .clear(load_start), .ena(accept_c), .data(data), .hit(hit_e0)
  );

  sig_matcher #(.NUM_BYTES(SIG_3F_LEN), .PATTERN(SIG_3F), .NEED(P3F_NEED)) u_match_3f (
    .clk(clk), .reset(reset), .clear(load_start), .ena(accept_c), .data(data), .hit(hit_3f)
  );

  sig_matcher #(.NUM_BYTES(SIG_FE_LEN), .PATTERN(SIG_FE), .NEED(FE_NEED)) u_match_fe (
    .clk(clk), .reset(reset), .clear(load_start), .ena(accept_c), .data(data), .hit(hit_fe)
  );

  sig_matcher #(.NUM_BYTES(SIG_E7_LEN), .PATTERN(SIG_E7), .NEED(E7_NEED)) u_match_e7 (
    .clk(clk), .reset(reset), .clear(load_start), .ena(accept_c), .data(data), .hit(hit_e7)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      scheme       <= SCH_UNKNOWN;
      superchip    <= 1'b0;
      scheme_valid <= 1'b0;
      rom_size     <= '0;
      sc_ref       <= '0;
      sc_ok        <= 1'b0;
    end else if (load_start) begin
      state        <= LOADING;
      busy         <= 1'b1;
      scheme_valid <= 1'b0;
      rom_size     <= '0;
      sc_ref       <= '0;
      sc_ok        <= 1'b0;
    end else begin
      if (accept_c) begin
        if (rom_size != SIZE_MAX) rom_size <= rom_size + 16'd1;
        // Byte 0 is the reference; bytes 1..255 must all repeat it.
        if (rom_size == 16'd0) begin
          sc_ref <= data;
          sc_ok  <= 1'b1;
        end else if ((rom_size < SC_WINDOW) && (data != sc_ref)) begin
          sc_ok <= 1'b0;
        end
      end
      case (state)
        LOADING: if (load_done) state <= RESOLVE;
        RESOLVE: begin
          state        <= DONE;
          busy         <= 1'b0;
          scheme       <= scheme_c;
          superchip    <= superchip_c;
          scheme_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bankswitch_detect.sv
// Scoreboard bench for bankswitch_detect: image-level reference model feeds
// an expectation queue that a monitor drains on each scheme_valid rise.
module tb_bankswitch_detect;

  typedef logic [7:0] byte_q [$];

  typedef struct {
    logic [3:0]  sch;
    logic        sc;
    logic [15:0] sz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        load_done = 1'b0;
  logic        busy;
  logic [3:0]  scheme;
  logic        superchip;
  logic        scheme_valid;
  logic [15:0] rom_size;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  byte_q sig_e0 = '{8'h8D, 8'hE0, 8'h1F};
  byte_q sig_3f = '{8'h85, 8'h3F};
  byte_q sig_fe = '{8'h20, 8'h00, 8'hD0, 8'hC6, 8'hC5};
  byte_q sig_e7 = '{8'hAD, 8'hE5, 8'hFF};

  bankswitch_detect dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ena(ena), .data(data),
    .load_done(load_done), .busy(busy), .scheme(scheme), .superchip(superchip),
    .scheme_valid(scheme_valid), .rom_size(rom_size)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Overlapping occurrence count of pat within img.
  function automatic int count_sig(input byte_q img, input byte_q pat);
    int n = 0;
    bit m;
    for (int i = 0; i + pat.size() <= img.size(); i++) begin
      m = 1'b1;
      for (int k = 0; k < pat.size(); k++) if (img[i+k] != pat[k]) m = 1'b0;
      if (m) n++;
    end
    return n;
  endfunction

  // Reference: scheme decision from the whole image at once.
  function automatic exp_t model(input byte_q img);
    exp_t e;
    int   n = img.size();
    bit   e0, p3f, fe, e7, ok;
    e0  = count_sig(img, sig_e0) >= 1;
    p3f = count_sig(img, sig_3f) >= 2;
    fe  = count_sig(img, sig_fe) >= 1;
    e7  = count_sig(img, sig_e7) >= 1;
    e.sz = (n > 65535) ? 16'hFFFF : 16'(n);
    if (n == 2048)       e.sch = 4'd0;
    else if (n == 4096)  e.sch = 4'd1;
    else if (n == 8192)  e.sch = e0 ? 4'd5 : p3f ? 4'd6 : fe ? 4'd7 : 4'd2;
    else if (n == 16384) e.sch = e7 ? 4'd8 : 4'd3;
    else if (n == 32768) e.sch = 4'd4;
    else                 e.sch = p3f ? 4'd6 : 4'd15;
    ok = (n >= 256);
    for (int i = 1; i < 256 && i < n; i++) if (img[i] != img[0]) ok = 1'b0;
    e.sc  = ok && (e.sch >= 4'd2) && (e.sch <= 4'd4);
    e.cyc = 0;
    return e;
  endfunction

  // Filler that avoids the first byte of every signature.
  function automatic byte_q make_img(input int n);
    byte_q q;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h8D || b == 8'h85 || b == 8'h20 || b == 8'hAD) b = 8'h11;
      q.push_back(b);
    end
    return q;
  endfunction

  function automatic byte_q plant(input byte_q q, input int off, input byte_q pat);
    byte_q r = q;
    for (int k = 0; k < pat.size(); k++) r[off+k] = pat[k];
    return r;
  endfunction

  task automatic push_expect(input byte_q img);
    exp_t e = model(img);
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    load_start = 1'b1; ena = 1'b0; load_done = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic stream(input byte_q img, input int n, input bit done_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        ena = 1'b0; data = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
      end
      ena = 1'b1; data = img[i];
      if (done_last && i == n - 1) begin
        push_expect(img);
        load_done = 1'b1;
      end
      @(posedge clk); #1;
      ena = 1'b0; load_done = 1'b0;
    end
  endtask

  task automatic load_image(input byte_q img, input bit done_last, input int gap_pct);
    pulse_start();
    stream(img, img.size(), done_last, gap_pct);
    if (!done_last) begin
      push_expect(img);
      load_done = 1'b1;
      @(posedge clk); #1;
      load_done = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle_beats(input int n);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1; data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    ena = 1'b0;
  endtask

  // Monitor: each rising scheme_valid retires one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (scheme_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("scheme", int'(scheme), int'(e.sch));
        chk("superchip", int'(superchip), int'(e.sc));
        chk("rom_size", int'(rom_size), int'(e.sz));
        chk("valid_latency_cycle", cyc, e.cyc);
      end
    end
    prev_valid <= scheme_valid;
  end

  initial begin
    byte_q img;
    int n;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_scheme", int'(scheme), 15);
    chk("reset_valid", int'(scheme_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rom_size", int'(rom_size), 0);
    @(posedge clk); #1;

    idle_beats(3);
    chk("idle_ena_rom_size", int'(rom_size), 0);
    chk("idle_ena_busy", int'(busy), 0);

    load_image(make_img(4096), 1'b0, 0);
    chk("4k_rom_size", int'(rom_size), 4096);
    idle_beats(3);
    chk("done_ena_rom_size", int'(rom_size), 4096);
    chk("done_valid_held", int'(scheme_valid), 1);

    load_image(plant(make_img(8192), 16'h100, sig_e0), 1'b0, 0);

    // Signature split across a restart must not match.
    img = plant(make_img(8192), 16'h100, sig_e0);
    pulse_start();
    stream(img, 16'h102, 1'b0, 0);
    chk("loading_busy", int'(busy), 1);
    img = make_img(8192);
    img[0] = 8'h1F;
    load_image(img, 1'b0, 0);

    load_image(plant(make_img(8192), 500, sig_3f), 1'b0, 0);
    load_image(plant(plant(make_img(8192), 500, sig_3f), 7000, sig_3f), 1'b0, 0);
    load_image(plant(plant(plant(make_img(8192), 500, sig_3f), 7000, sig_3f), 3000, sig_e0),
               1'b0, 0);

    img = make_img(16384);
    for (int i = 0; i < 256; i++) img[i] = 8'hFF;
    load_image(img, 1'b0, 0);
    img[200] = 8'h00;
    load_image(img, 1'b0, 0);

    // Reset in the middle of a load discards it.
    pulse_start();
    stream(make_img(8192), 1000, 1'b0, 0);
    reset = 1'b1; ena = 1'b1; data = 8'h8D;
    @(posedge clk); #1;
    reset = 1'b0; ena = 1'b0;
    @(negedge clk);
    chk("midreset_valid", int'(scheme_valid), 0);
    chk("midreset_scheme", int'(scheme), 15);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_rom_size", int'(rom_size), 0);
    @(posedge clk); #1;

    load_image(make_img(2048), 1'b0, 0);
    load_image(make_img(3000), 1'b0, 0);
    load_image(make_img(4096), 1'b1, 0);

    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(300, 1500);
      img = make_img(n);
      if ($urandom_range(0, 1) == 1) img = plant(plant(img, 10, sig_3f), n - 20, sig_3f);
      if ($urandom_range(0, 1) == 1) img = plant(img, n / 2, sig_e7);
      load_image(img, 1'(r), 25);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
